// File: rtl/sprite_blit_sequencer.sv
// rtl/sprite_blit_sequencer.sv - scans a 32x32 sprite from the image decoder and writes visible pixels to the framebuffer
module sprite_blit_sequencer #(
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter int         ADDR_W      = 19,
    parameter logic [3:0] TRANSPARENT = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_img,
    output logic [4:0]        spr_clm,
    output logic [4:0]        spr_row,
    output logic [9:0]        spr_img,
    input  logic [3:0]        spr_color,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
    localparam logic [9:0]  SCREEN_H_L = 10'(SCREEN_H);

    state_t              state;
    state_t              state_nxt;
    logic [9:0]          x_q;
    logic [8:0]          y_q;
    logic [9:0]          img_q;
    logic [4:0]          dy;
    logic [4:0]          dx;
    logic [10:0]         x_sum;
    logic [9:0]          y_sum;
    logic [ADDR_W-1:0]   lin_addr;
    logic                slot_free;
    logic                visible;
    logic                last_px;

    // Sums carry one extra bit so off-screen positions never alias back on-screen.
    assign x_sum     = {1'b0, x_q} + {6'd0, dx};
    assign y_sum     = {1'b0, y_q} + {5'd0, dy};
    assign lin_addr  = ADDR_W'(y_sum) * ADDR_W'(SCREEN_W) + ADDR_W'(x_sum);
    assign slot_free = !fb_we || fb_ready;
    assign visible   = (spr_color != TRANSPARENT) && (x_sum < SCREEN_W_L) && (y_sum < SCREEN_H_L);
    assign last_px   = (dy == 5'd31) && (dx == 5'd31);

    assign spr_clm = dy;
    assign spr_row = dx;
    assign spr_img = img_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (slot_free && last_px) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (slot_free) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            img_q   <= '0;
            dy      <= '0;
            dx      <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fb_we <= 1'b0;
                    if (cmd_valid) begin
                        x_q   <= cmd_x;
                        y_q   <= cmd_y;
                        img_q <= cmd_img;
                        dy    <= '0;
                        dx    <= '0;
                    end
                end
                SCAN: begin
                    // A stalled write freezes both the scan position and the write port.
                    if (slot_free) begin
                        fb_we <= visible;
                        if (visible) begin
                            fb_addr <= lin_addr;
                            fb_data <= spr_color;
                        end
                        dx <= dx + 5'd1;
                        if (dx == 5'd31) begin
                            dy <= dy + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (fb_ready) begin
                        fb_we <= 1'b0;
                    end
                end
                default: fb_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blit_sequencer.sv
// tb/tb_sprite_blit_sequencer.sv - directed bench for sprite_blit_sequencer
module tb_sprite_blit_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_img;
    logic [4:0]  spr_clm;
    logic [4:0]  spr_row;
    logic [9:0]  spr_img;
    logic [3:0]  spr_color;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          base;
    int          cyc;
    int          d0;
    int          n;
    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    sprite_blit_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_img   (cmd_img),
        .spr_clm   (spr_clm),
        .spr_row   (spr_row),
        .spr_img   (spr_img),
        .spr_color (spr_color),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ready  (fb_ready),
        .busy      (busy),
        .done      (done)
    );

    // Image 0: transparent up to (5,12), then (dy+dx+3) mod 16; other ids: dx ^ id.
    function automatic logic [3:0] pix(input logic [9:0] img, input logic [4:0] dy, input logic [4:0] dx);
        if (img == 10'd0) begin
            if (dy < 5'd5 || (dy == 5'd5 && dx < 5'd13)) return 4'd0;
            return 4'(dy + dx + 5'd3);
        end
        return dx[3:0] ^ img[3:0];
    endfunction

    always_comb spr_color = pix(spr_img, spr_clm, spr_row);

    always @(posedge clk) begin
        if (rst_n && fb_we && fb_ready) obs_q.push_back({fb_addr, fb_data});
        if (rst_n && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input int x, input int y, input logic [9:0] img);
        exp_q.delete();
        for (int dy = 0; dy < 32; dy++) begin
            for (int dx = 0; dx < 32; dx++) begin
                logic [3:0] c;
                c = pix(img, 5'(dy), 5'(dx));
                if (c != 4'd0 && x + dx < 640 && y + dy < 480)
                    exp_q.push_back({19'((y + dy) * 640 + x + dx), c});
            end
        end
    endtask

    function automatic int seq_bad(input int b);
        if (obs_q.size() - b != exp_q.size()) return 1;
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[b + i] !== exp_q[i]) return 1;
        return 0;
    endfunction

    task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [9:0] img);
        int k;
        @(negedge clk);
        cmd_x     = x;
        cmd_y     = y;
        cmd_img   = img;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int c);
        c = 1;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, " done"}, done, 1);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " cmd_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_img   = '0;
        fb_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst fb_we", fb_we, 0);
        chk("rst fb_addr", fb_addr, 0);
        chk("rst fb_data", fb_data, 0);
        chk("rst spr_clm", spr_clm, 0);
        chk("rst spr_row", spr_row, 0);
        chk("rst spr_img", spr_img, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        rst_n = 1'b1;

        build_exp(0, 0, 10'd0);
        base = obs_q.size();
        d0   = done_cnt;
        send(10'd0, 9'd0, 10'd0);
        chk("c1 busy", busy, 1);
        chk("c1 cmd_ready", cmd_ready, 0);
        wait_done("c1", cyc);
        chk("c1 cycles", cyc, 1025);
        chk("c1 count", obs_q.size() - base, exp_q.size());
        chk("c1 first addr", obs_q[base][22:4], 3213);
        chk("c1 first data", obs_q[base][3:0], 4'b0101);
        chk("c1 sequence", seq_bad(base), 0);
        chk("c1 done pulses", done_cnt - d0, 1);

        build_exp(620, 0, 10'd0);
        base = obs_q.size();
        send(10'd620, 9'd0, 10'd0);
        wait_done("c2", cyc);
        chk("c2 count", obs_q.size() - base, exp_q.size());
        chk("c2 first addr", obs_q[base][22:4], 3833);
        chk("c2 sequence", seq_bad(base), 0);

        build_exp(0, 0, 10'd0);
        base     = obs_q.size();
        fb_ready = 1'b0;
        send(10'd0, 9'd0, 10'd0);
        n = 0;
        while (!fb_we && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("c3 stall we", fb_we, 1);
        repeat (4) @(negedge clk);
        chk("c3 held we", fb_we, 1);
        chk("c3 held addr", fb_addr, 3213);
        chk("c3 held data", fb_data, 5);
        chk("c3 frozen clm", spr_clm, 5);
        chk("c3 frozen row", spr_row, 14);
        fb_ready = 1'b1;
        wait_done("c3", cyc);
        chk("c3 count", obs_q.size() - base, exp_q.size());
        chk("c3 sequence", seq_bad(base), 0);

        build_exp(0, 479, 10'd0);
        base = obs_q.size();
        send(10'd0, 9'd479, 10'd0);
        wait_done("c4", cyc);
        chk("c4 cycles", cyc, 1025);
        chk("c4 count", obs_q.size() - base, 0);

        send(10'd0, 9'd0, 10'd0);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("c5 async fb_we", fb_we, 0);
        chk("c5 async busy", busy, 0);
        chk("c5 async cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        build_exp(0, 0, 10'd0);
        base = obs_q.size();
        send(10'd0, 9'd0, 10'd0);
        chk("c5 restart clm", spr_clm, 0);
        chk("c5 restart row", spr_row, 0);
        wait_done("c5", cyc);
        chk("c5 sequence", seq_bad(base), 0);

        build_exp(0, 0, 10'd0);
        base = obs_q.size();
        send(10'd0, 9'd0, 10'd0);
        repeat (9) @(negedge clk);
        cmd_x     = 10'd100;
        cmd_y     = 9'd50;
        cmd_img   = 10'd7;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("c6 held off", cmd_ready, 0);
        wait_done("c6a", cyc);
        chk("c6a sequence", seq_bad(base), 0);
        build_exp(100, 50, 10'd7);
        base = obs_q.size();
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("c6 accepted busy", busy, 1);
        chk("c6 spr_img", spr_img, 7);
        chk("c6 start row", spr_row, 0);
        wait_done("c6b", cyc);
        chk("c6b cycles", cyc, 1025);
        chk("c6b count", obs_q.size() - base, exp_q.size());
        chk("c6b sequence", seq_bad(base), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
